// File: rtl/econet_rx_deframer.sv
// -----------------------------------------------------------------------------
// econet_rx_deframer
//
// Receive-side HDLC-style deframer for an Econet line. It tracks runs of 1s
// on the synchronised line bit stream to find flags (01111110), stuffed zeros
// and abort sequences. Payload bits are packed LSB-first into bytes, and frame
// boundary and status strobes are produced for the downstream FCS block and
// the consumer. The FCS itself is computed outside this block: rx_valid
// enables it, fcs_clear re-initialises it, and its running value comes back
// in on fcsval.
//
// Optional feature: define ECONET_RX_IDLE_EN to enable line-idle detection
// (fifteen or more consecutive 1s). With the macro undefined, line_idle is
// tied low.
//
// Parameters
//   FCSGOOD    FCS residue that marks a frame good
//   MIN_BYTES  minimum bytes (payload plus FCS) for a good frame
//
// Ports
//   econet_clk   in   single clock, rising edge
//   reset        in   asynchronous, active-high reset
//   rx_bit       in   received line bit, qualified by bit_valid
//   bit_valid    in   one-cycle strobe per line bit
//   fcsval       in   [15:0] running FCS from the downstream FCS block
//   fcs_clear    out  one-cycle pulse: re-initialise the FCS block
//   rx_data      out  [7:0] assembled byte, first-received bit in bit 0
//   rx_valid     out  one-cycle strobe: rx_data valid (also FCS enable)
//   frame_start  out  pulse with the first rx_valid of a frame
//   frame_end    out  pulse on the closing flag of a non-empty frame
//   frame_good   out  frame status, valid from frame_end, held until the
//                     next frame_end or frame_abort
//   frame_abort  out  pulse: abort sequence received inside a frame
//   line_idle    out  high while the line is idle (optional feature)
// -----------------------------------------------------------------------------
module econet_rx_deframer #(
  parameter logic [15:0] FCSGOOD   = 16'hF0B8,
  parameter int          MIN_BYTES = 4
) (
  input  logic        econet_clk,
  input  logic        reset,
  input  logic        rx_bit,
  input  logic        bit_valid,
  input  logic [15:0] fcsval,
  output logic        fcs_clear,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_start,
  output logic        frame_end,
  output logic        frame_good,
  output logic        frame_abort,
  output logic        line_idle
);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,  // searching for a flag
    S_FLAG = 2'd1,  // flag seen, no byte of the frame yet
    S_DATA = 2'd2   // inside a frame
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ones_q, ones_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_end_q, frame_end_d;
  logic        frame_good_q, frame_good_d;
  logic        frame_abort_q, frame_abort_d;
  logic        fcs_clear_q, fcs_clear_d;

  // Line-symbol decode. All of these look at the run length *before* the
  // current bit is counted.
  logic       is_flag;   // 0 after exactly six 1s
  logic       is_stuff;  // 0 after exactly five 1s: inserted by transmitter
  logic       is_sixth;  // sixth 1: part of a flag, never payload
  logic       is_abort;  // seventh 1
  logic [7:0] shift_val;

  assign is_flag   = !rx_bit && (ones_q == 4'd6);
  assign is_stuff  = !rx_bit && (ones_q == 4'd5);
  assign is_sixth  =  rx_bit && (ones_q == 4'd5);
  assign is_abort  =  rx_bit && (ones_q == 4'd6);
  // Bits arrive LSB first: shift in at the top so the first bit ends in bit 0.
  assign shift_val = {rx_bit, shreg_q[7:1]};

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    ones_d        = ones_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    shreg_d       = shreg_q;
    rx_data_d     = rx_data_q;
    frame_good_d  = frame_good_q;
    rx_valid_d    = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    frame_abort_d = 1'b0;
    fcs_clear_d   = 1'b0;

    if (bit_valid) begin
      // Consecutive-ones run length, saturating so a long idle line cannot
      // wrap back into the flag/abort codes.
      if (rx_bit) begin
        ones_d = (ones_q == 4'd15) ? 4'd15 : ones_q + 4'd1;
      end else begin
        ones_d = 4'd0;
      end

      if (is_flag) begin
        // A flag is recognised in every state and always opens a new frame,
        // so the closing flag of one frame doubles as the opening flag of
        // the next.
        state_d     = S_FLAG;
        bit_cnt_d   = 3'd0;
        byte_cnt_d  = 8'd0;
        fcs_clear_d = 1'b1;
        if (state_q == S_DATA) begin
          frame_end_d  = 1'b1;
          // A byte-aligned frame leaves exactly six flag bits in the counter:
          // the flag's leading 0 plus five 1s (the sixth 1 is never shifted).
          frame_good_d = (fcsval == FCSGOOD) && (bit_cnt_q == 3'd6) &&
                         (byte_cnt_q >= 8'(MIN_BYTES));
        end
      end else if (state_q != S_HUNT) begin
        if (is_abort) begin
          state_d    = S_HUNT;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 8'd0;
          if (state_q == S_DATA) begin
            frame_abort_d = 1'b1;
            frame_good_d  = 1'b0;
          end
        end else if (!is_stuff && !is_sixth) begin
          shreg_d   = shift_val;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = shift_val;
            rx_valid_d = 1'b1;
            if (byte_cnt_q != 8'hFF) begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
            if (state_q == S_FLAG) begin
              frame_start_d = 1'b1;
              state_d       = S_DATA;
            end
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge econet_clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_HUNT;
      ones_q        <= 4'd0;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= 8'd0;
      shreg_q       <= 8'h00;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_good_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      fcs_clear_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ones_q        <= ones_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frame_good_q  <= frame_good_d;
      frame_abort_q <= frame_abort_d;
      fcs_clear_q   <= fcs_clear_d;
    end
  end

`ifdef ECONET_RX_IDLE_EN
  logic line_idle_q, line_idle_d;

  // Rises after the fifteenth consecutive 1, falls after the next 0.
  always_comb begin
    line_idle_d = line_idle_q;
    if (bit_valid) begin
      line_idle_d = rx_bit && (ones_q >= 4'd14);
    end
  end

  always_ff @(posedge econet_clk or posedge reset) begin
    if (reset) begin
      line_idle_q <= 1'b0;
    end else begin
      line_idle_q <= line_idle_d;
    end
  end

  assign line_idle = line_idle_q;
`else
  assign line_idle = 1'b0;
`endif

  assign fcs_clear   = fcs_clear_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign frame_good  = frame_good_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_econet_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_econet_rx_deframer
//
// Directed bench for econet_rx_deframer. The stimulus side pushes the expected
// output events (bytes, frame ends, aborts) into a queue before driving the
// bits that cause them; a monitor pops and compares whenever the DUT raises
// rx_valid, frame_end or frame_abort. fcsval is driven directly with the
// residue each scenario calls for.
// -----------------------------------------------------------------------------
module tb_econet_rx_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_bit;
  logic        bit_valid;
  logic [15:0] fcsval;
  logic        fcs_clear;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_start;
  logic        frame_end;
  logic        frame_good;
  logic        frame_abort;
  logic        line_idle;

  always #5 clk = ~clk;

  econet_rx_deframer #(
    .FCSGOOD  (16'hF0B8),
    .MIN_BYTES(4)
  ) dut (
    .econet_clk (clk),
    .reset      (rst),
    .rx_bit     (rx_bit),
    .bit_valid  (bit_valid),
    .fcsval     (fcsval),
    .fcs_clear  (fcs_clear),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .frame_good (frame_good),
    .frame_abort(frame_abort),
    .line_idle  (line_idle)
  );

`ifdef ECONET_RX_IDLE_EN
  localparam logic IDLE_EXP = 1'b1;
`else
  localparam logic IDLE_EXP = 1'b0;
`endif

  typedef enum {EV_BYTE, EV_END, EV_ABORT} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    logic       start;
    logic       good;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_checks       = 0;
  int  n_fail         = 0;
  int  fcs_clear_seen = 0;
  int  flags_sent     = 0;
  int  tx_ones        = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input logic [7:0] d,
                         input logic s, input logic g);
    ev_t e;
    e.kind  = k;
    e.data  = d;
    e.start = s;
    e.good  = g;
    exp_q.push_back(e);
  endtask

  // One line bit: strobe high for one cycle, low for one cycle.
  task automatic send_bit(input logic b);
    @(negedge clk);
    rx_bit    = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    tx_ones   = b ? tx_ones + 1 : 0;
  endtask

  // Payload bit with transmitter-side zero stuffing after five 1s.
  task automatic send_data_bit(input logic b);
    send_bit(b);
    if (b && tx_ones == 5) send_bit(1'b0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic first);
    push_ev(EV_BYTE, d, first, 1'b0);
    for (int i = 0; i < 8; i++) send_data_bit(d[i]);
  endtask

  task automatic send_raw_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic send_flag();
    flags_sent++;
    send_bit(1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    send_bit(1'b0);
  endtask

  // Scoreboard monitor: samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (fcs_clear) fcs_clear_seen++;
    if (rx_valid || frame_end || frame_abort) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got valid=%b end=%b abort=%b data=0x%h, expected no event",
                 rx_valid, frame_end, frame_abort, rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        case (mon_e.kind)
          EV_BYTE: begin
            check("byte_event_kind", {rx_valid, frame_end, frame_abort}, 3'b100);
            check("rx_data", rx_data, mon_e.data);
            check("frame_start", frame_start, mon_e.start);
          end
          EV_END: begin
            check("end_event_kind", {rx_valid, frame_end, frame_abort}, 3'b010);
            check("frame_good", frame_good, mon_e.good);
          end
          default: begin
            check("abort_event_kind", {rx_valid, frame_end, frame_abort}, 3'b001);
          end
        endcase
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  logic [7:0] good_frame [11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                                  8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
  logic [7:0] bad_frame  [4]  = '{8'hFF, 8'h00, 8'h00, 8'h00};
  logic [7:0] short_frame [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

  initial begin
    rst       = 1'b1;
    rx_bit    = 1'b0;
    bit_valid = 1'b0;
    fcsval    = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_start", frame_start, 1'b0);
    check("reset_frame_end", frame_end, 1'b0);
    check("reset_frame_good", frame_good, 1'b0);
    check("reset_frame_abort", frame_abort, 1'b0);
    check("reset_fcs_clear", fcs_clear, 1'b0);
    check("reset_line_idle", line_idle, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good frame "123456789" + FCS 0x6E 0x90
    fcsval = 16'hF0B8;
    send_flag();
    for (int i = 0; i < 11; i++) send_byte(good_frame[i], i == 0);
    push_ev(EV_END, 8'h00, 1'b0, 1'b1);
    send_flag();
    repeat (6) @(negedge clk);
    check("frame_good_held", frame_good, 1'b1);

    // 0xFF with stuffed zero, then zeros; FCS residue wrong
    fcsval = 16'h1234;
    for (int i = 0; i < 4; i++) send_byte(bad_frame[i], i == 0);
    push_ev(EV_END, 8'h00, 1'b0, 1'b0);
    send_flag();
    repeat (2) @(negedge clk);
    check("frame_good_after_bad_fcs", frame_good, 1'b0);

    // Good frame with three extra 0 bits: misaligned, extra 0xF0 byte
    fcsval = 16'hF0B8;
    for (int i = 0; i < 11; i++) send_byte(good_frame[i], i == 0);
    push_ev(EV_BYTE, 8'hF0, 1'b0, 1'b0);
    push_ev(EV_END, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    send_flag();
    // Back-to-back empty frames: no frame_end expected
    for (int i = 0; i < 3; i++) send_flag();

    // MIN_BYTES boundary: 3 bytes fails, 4 bytes passes
    for (int i = 0; i < 3; i++) send_byte(short_frame[i], i == 0);
    push_ev(EV_END, 8'h00, 1'b0, 1'b0);
    send_flag();
    for (int i = 0; i < 4; i++) send_byte(short_frame[i], i == 0);
    push_ev(EV_END, 8'h00, 1'b0, 1'b1);
    send_flag();
    repeat (2) @(negedge clk);
    check("frame_good_min_bytes", frame_good, 1'b1);

    // Abort inside a frame
    send_flag();
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    push_ev(EV_ABORT, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    repeat (2) @(negedge clk);
    check("frame_good_cleared_by_abort", frame_good, 1'b0);
    // In HUNT: unflagged data produces nothing
    send_raw_byte(8'h55);

    // Seven 1s straight after a flag: back to HUNT with no abort pulse
    send_flag();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    send_raw_byte(8'h55);

    // Idle detection
    send_bit(1'b0);
    for (int i = 0; i < 14; i++) send_bit(1'b1);
    check("line_idle_after_14_ones", line_idle, 1'b0);
    send_bit(1'b1);
    check("line_idle_after_15_ones", line_idle, IDLE_EXP);
    send_bit(1'b1);
    check("line_idle_after_16_ones", line_idle, IDLE_EXP);
    send_bit(1'b0);
    check("line_idle_after_zero", line_idle, 1'b0);

    // Reset mid-frame: frame discarded, no end/abort
    send_flag();
    send_byte(8'hA5, 1'b1);
    send_data_bit(1'b1);
    send_data_bit(1'b1);
    send_data_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_rx_data", rx_data, 8'h00);
    check("midreset_frame_end", frame_end, 1'b0);
    check("midreset_frame_abort", frame_abort, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    send_raw_byte(8'hA5);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("fcs_clear_count", fcs_clear_seen, flags_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/econet_rx_deframer.md
ECONET_RX_DEFRAMER -- requirements
Module: econet_rx_deframer

Interface
REQ-001 Parameter FCSGOOD, default 16'hF0B8: FCS residue that marks a frame good.
REQ-002 Parameter MIN_BYTES, default 4: minimum bytes (payload plus FCS) for a valid frame.
REQ-003 econet_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_bit  input  1  received line bit, already synchronised; valid only when bit_valid is high.
REQ-006 bit_valid  input  1  one-cycle strobe per line bit; strobes are at least 2 econet_clk cycles apart.
REQ-007 fcsval  input  16  running FCS from the downstream FCS block.
REQ-008 fcs_clear  output  1  one-cycle pulse that re-initialises the FCS block.
REQ-009 rx_data  output  8  assembled byte, LSB received first.
REQ-010 rx_valid  output  1  one-cycle strobe: rx_data valid; also the FCS block enable.
REQ-011 frame_start  output  1  one-cycle pulse coincident with the first rx_valid of a frame.
REQ-012 frame_end  output  1  one-cycle pulse on the closing flag of a non-empty frame.
REQ-013 frame_good  output  1  qualifies frame_end; held until the next frame_end or frame_abort.
REQ-014 frame_abort  output  1  one-cycle pulse: abort sequence received inside a frame.
REQ-015 line_idle  output  1  high while the line is idle (see Configuration).

Function
REQ-016 The block SHALL keep a 4-bit consecutive-ones counter, saturating at 15 and cleared by any 0 bit.
REQ-017 The block SHALL implement states HUNT, FLAG and DATA; bits are processed only on bit_valid.
REQ-018 A 0 bit arriving after exactly five 1s SHALL be deleted (stuffed) in FLAG and DATA.
REQ-019 A 0 bit arriving after exactly six 1s SHALL be a flag, recognised in every state.
REQ-020 Receipt of a seventh consecutive 1 SHALL be an abort; DATA->HUNT with frame_abort pulsed; FLAG->HUNT without pulse.
REQ-021 A sixth consecutive 1 SHALL NOT be appended to the byte being assembled.
REQ-022 In FLAG and DATA, every non-deleted, non-sixth bit SHALL be shifted into the byte register, filling bit 0 first, and SHALL increment a 3-bit bit counter.
REQ-023 When the bit counter wraps from 7 to 0, rx_data SHALL update and rx_valid SHALL pulse in the cycle after that bit_valid.
REQ-024 The first rx_valid after a flag SHALL pulse frame_start with it and move FLAG->DATA.
REQ-025 On flag in HUNT: ->FLAG, fcs_clear pulsed.
REQ-026 On flag in FLAG: stay FLAG, fcs_clear pulsed, no frame_end (empty frame).
REQ-027 On flag in DATA: frame_end pulsed the cycle after that bit_valid, fcs_clear pulsed in the same cycle, ->FLAG.
REQ-028 frame_good SHALL be 1 only if fcsval == FCSGOOD, the bit counter equals 6 (flag's 0 plus five 1s appended after a whole byte), and the frame's byte count >= MIN_BYTES.
REQ-029 The frame's byte count SHALL saturate at 255; on every flag the bit counter and byte count SHALL clear.
REQ-030 rx_data bytes SHALL include the two FCS bytes; stripping them is the consumer's task.
REQ-031 A flag's final 0 SHALL also serve as opening flag of the next frame (back-to-back frames).

Reset
REQ-032 On reset: state HUNT, counters 0, rx_data 8'h00, all single-bit outputs 0.
REQ-033 Reset mid-frame SHALL discard the frame with no frame_end or frame_abort.

Configuration
REQ-034 Macro ECONET_RX_IDLE_EN defined: line_idle SHALL rise the cycle after the fifteenth consecutive 1 and fall the cycle after the next 0 bit.
REQ-035 Macro ECONET_RX_IDLE_EN undefined: line_idle SHALL be constant 0 and no other behaviour changes.

Verification
REQ-036 Flag, bytes 0x31..0x39 ("123456789"), 0x6E, 0x90, flag -> 11 rx_valid with those values, frame_start on first, frame_end=1, frame_good=1, one fcs_clear per flag.
REQ-037 Flag, byte 0xFF sent as 11111 0 111, then 0x00, 0x00, 0x00, flag -> rx_data 0xFF then 0x00 x3; stuffed 0 deleted; frame_good=0 (FCS mismatch).
REQ-038 Flag, 0x12, 0x34, then seven 1s -> two rx_valid, frame_abort=1, state HUNT, no frame_end.
REQ-039 Good frame of REQ-036 with 3 extra 0 bits before closing flag -> frame_end=1, frame_good=0; three back-to-back flags -> no frame_end.
REQ-040 Sixteen 1s with ECONET_RX_IDLE_EN defined -> line_idle=1 after the 15th; next 0 -> line_idle=0; undefined -> line_idle stays 0.
